huffman_encoder: RTL and testbench



---
 rtl/huffman_pkg.sv | 44 ++++
 rtl/huffman_code_lut.sv | 18 +
 rtl/huffman_encoder.sv | 138 +++++++++++++
 tb/tb_huffman_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared Huffman code definitions for the encoder and decoder.
package huffman_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned MAX_LEN = 6;
    localparam int unsigned BUF_W   = WORD_W + MAX_LEN;
    localparam int unsigned SYM_W   = 4;
    localparam int unsigned LEN_W   = 3;
    localparam int unsigned FILL_W  = 6;
    localparam int unsigned BITS_W  = 6;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Codes right-aligned, indexed by symbol; entry 15 first.
    localparam logic [15:0][MAX_LEN-1:0] CODE_TAB = {
        6'b000101,  // 15
        6'b000100,  // 14
        6'b000000,  // 13 uncoded
        6'b000111,  // 12
        6'b000000,  // 11 uncoded
        6'b000000,  // 10
        6'b000111,  // 9
        6'b000110,  // 8
        6'b001101,  // 7
        6'b000011,  // 6
        6'b000010,  // 5
        6'b011001,  // 4
        6'b011000,  // 3
        6'b000101,  // 2
        6'b000100,  // 1
        6'b000001   // 0
    };

    // Code lengths indexed by symbol; zero marks an uncoded symbol.
    localparam logic [15:0][LEN_W-1:0] LEN_TAB = {
        3'd6, 3'd6, 3'd0, 3'd6, 3'd0, 3'd4, 3'd4, 3'd6,
        3'd5, 3'd4, 3'd4, 3'd6, 3'd6, 3'd4, 3'd4, 3'd1
    };

endpackage

// File: rtl/huffman_code_lut.sv
// Symbol to prefix-code lookup: right-aligned code, length and invalid flag.
module huffman_code_lut
    import huffman_pkg::*;
(
    input  logic [SYM_W-1:0]   sym,
    output logic [MAX_LEN-1:0] code,
    output logic [LEN_W-1:0]   len,
    output logic               invalid
);

    // Table lookup; a zero length marks the symbol as uncoded
    always_comb begin
        code    = CODE_TAB[sym];
        len     = LEN_TAB[sym];
        invalid = (LEN_TAB[sym] == '0);
    end

endmodule

// File: rtl/huffman_encoder.sv
// Streaming Huffman encoder: packs variable-length codes MSB-first into
// 32-bit words with valid/ready on both sides and a zero-padding flush.
// Optional: define HENC_STATS_EN to add sym_count/bit_count statistics ports.
module huffman_encoder
    import huffman_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SYM_W-1:0]   sym_in,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic               flush,
    output logic [WORD_W-1:0]  out_word,
    output logic [BITS_W-1:0]  out_bits,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               flush_done,
    output logic               sym_err
`ifdef HENC_STATS_EN
    ,
    output logic [CNT_W-1:0]   sym_count,
    output logic [CNT_W-1:0]   bit_count
`endif
);

    state_t              state;
    logic [BUF_W-1:0]    bit_buf;
    logic [FILL_W-1:0]   fill;

    logic [MAX_LEN-1:0]  lut_code;
    logic [LEN_W-1:0]    lut_len;
    logic                lut_invalid;

    logic                accept;
    logic                out_free;
    logic                word_ready;
    logic [FILL_W-1:0]   fill_after;
    logic [FILL_W-1:0]   shamt;
    logic [BUF_W-1:0]    placed;
    logic [WORD_W-1:0]   pad_mask;

    huffman_code_lut u_lut (
        .sym     (sym_in),
        .code    (lut_code),
        .len     (lut_len),
        .invalid (lut_invalid)
    );

    // Full buffer blocks new symbols, which keeps 31+6 bits inside the buffer
    assign sym_ready = (state == ST_RUN) && (fill < FILL_W'(WORD_W));

    // Handshake qualifiers and the left-aligned placement of the incoming code
    always_comb begin
        accept     = sym_valid && sym_ready;
        out_free   = !out_valid || out_ready;
        word_ready = (fill >= FILL_W'(WORD_W));
        fill_after = fill + (accept ? FILL_W'(lut_len) : '0);
        shamt      = FILL_W'(BUF_W) - fill - FILL_W'(lut_len);
        placed     = BUF_W'(lut_code) << shamt;
        pad_mask   = ~({WORD_W{1'b1}} >> fill);
    end

    // Buffer, output register and RUN/DRAIN control
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_RUN;
            bit_buf    <= '0;
            fill       <= '0;
            out_word   <= '0;
            out_bits   <= '0;
            out_valid  <= 1'b0;
            flush_done <= 1'b0;
            sym_err    <= 1'b0;
        end else begin
            flush_done <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && lut_invalid) begin
                sym_err <= 1'b1;
            end

            // Full words take priority; a partial word only leaves while draining
            if (word_ready && out_free) begin
                out_word  <= bit_buf[BUF_W-1 -: WORD_W];
                out_bits  <= BITS_W'(WORD_W);
                out_valid <= 1'b1;
                bit_buf   <= bit_buf << WORD_W;
                fill      <= fill - FILL_W'(WORD_W);
            end else if ((state == ST_DRAIN) && out_free && (fill != '0)) begin
                out_word  <= bit_buf[BUF_W-1 -: WORD_W] & pad_mask;
                out_bits  <= BITS_W'(fill);
                out_valid <= 1'b1;
                bit_buf   <= '0;
                fill      <= '0;
            end else if (accept && !lut_invalid) begin
                bit_buf <= bit_buf | placed;
                fill    <= fill_after;
            end

            case (state)
                ST_RUN: begin
                    if (flush && sym_ready) begin
                        // Nothing buffered and nothing pending: finish at once
                        if ((fill_after == '0) && out_free) begin
                            flush_done <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((fill == '0) && out_free) begin
                        flush_done <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef HENC_STATS_EN
    // Free-running counts of coded symbols and appended code bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            sym_count <= '0;
            bit_count <= '0;
        end else if (accept && !lut_invalid) begin
            sym_count <= sym_count + CNT_W'(1);
            bit_count <= bit_count + CNT_W'(lut_len);
        end
    end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed self-checking bench for huffman_encoder.
module tb_huffman_encoder;

    logic        clk;
    logic        rst;
    logic [3:0]  sym_in;
    logic        sym_valid;
    logic        sym_ready;
    logic        flush;
    logic [31:0] out_word;
    logic [5:0]  out_bits;
    logic        out_valid;
    logic        out_ready;
    logic        flush_done;
    logic        sym_err;
`ifdef HENC_STATS_EN
    logic [31:0] sym_count;
    logic [31:0] bit_count;
`endif

    int tests;
    int fails;
    int done_cnt;
    logic [31:0] got_word[$];
    logic [5:0]  got_bits[$];

    huffman_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .flush      (flush),
        .out_word   (out_word),
        .out_bits   (out_bits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush_done (flush_done),
        .sym_err    (sym_err)
`ifdef HENC_STATS_EN
        ,
        .sym_count  (sym_count),
        .bit_count  (bit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record output handshakes and flush_done pulses mid-cycle
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            got_word.push_back(out_word);
            got_bits.push_back(out_bits);
        end
        if (rst && flush_done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        got_word.delete();
        got_bits.delete();
        done_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one symbol and hold it until accepted (called at posedge+1)
    task automatic send_sym(input logic [3:0] s);
        int guard;
        guard = 0;
        sym_in    = s;
        sym_valid = 1'b1;
        @(negedge clk);
        while (!sym_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            tests++; fails++;
            $display("FAIL send_sym timeout: sym_ready stuck at %0b, expected 1", sym_ready);
        end
        @(posedge clk); #1;
        sym_valid = 1'b0;
    endtask

    task automatic do_flush();
        int guard;
        guard = 0;
        flush = 1'b1;
        @(negedge clk);
        while (!sym_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            tests++; fails++;
            $display("FAIL do_flush timeout: sym_ready stuck at %0b, expected 1", sym_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(3);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
        tests++; if (out_word !== 32'h0) begin fails++; $display("FAIL reset_out_word: got %h exp 00000000", out_word); end
        tests++; if (out_bits !== 6'd0) begin fails++; $display("FAIL reset_out_bits: got %0d exp 0", out_bits); end
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done: got %0b exp 0", flush_done); end
        tests++; if (sym_err !== 1'b0) begin fails++; $display("FAIL reset_sym_err: got %0b exp 0", sym_err); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        tests++; if (sym_ready !== 1'b1) begin fails++; $display("FAIL reset_sym_ready: got %0b exp 1", sym_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        clear_log();
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) send_sym(4'd0);
        // Now in cycle N+1 after the 32nd accept
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_n1: out_valid got %0b exp 0", out_valid); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL latency_n2: out_valid got %0b exp 1", out_valid); end
        tests++; if (out_word !== 32'hFFFF_FFFF) begin fails++; $display("FAIL full_word: got %h exp ffffffff", out_word); end
        idle(5);
        tests++; if (got_word.size() != 1) begin fails++; $display("FAIL full_word_count: got %0d exp 1", got_word.size()); end
        else begin
            tests++; if (got_bits[0] !== 6'd32) begin fails++; $display("FAIL full_word_bits: got %0d exp 32", got_bits[0]); end
        end
        tests++; if (done_cnt != 0) begin fails++; $display("FAIL full_word_no_done: got %0d exp 0", done_cnt); end
    endtask

    task automatic test_flush_mixed();
        logic [3:0] seq [8];
        seq = '{4'd9, 4'd2, 4'd1, 4'd6, 4'd5, 4'd10, 4'd7, 4'd3};
        clear_log();
        for (int i = 0; i < 8; i++) send_sym(seq[i]);
        do_flush();
        idle(8);
        tests++; if (got_word.size() != 2) begin fails++; $display("FAIL mixed_count: got %0d exp 2", got_word.size()); end
        else begin
            tests++; if (got_word[0] !== 32'h7543206B) begin fails++; $display("FAIL mixed_word0: got %h exp 7543206b", got_word[0]); end
            tests++; if (got_bits[0] !== 6'd32) begin fails++; $display("FAIL mixed_bits0: got %0d exp 32", got_bits[0]); end
            tests++; if (got_word[1] !== 32'h0) begin fails++; $display("FAIL mixed_word1: got %h exp 00000000", got_word[1]); end
            tests++; if (got_bits[1] !== 6'd3) begin fails++; $display("FAIL mixed_bits1: got %0d exp 3", got_bits[1]); end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL mixed_done: got %0d exp 1", done_cnt); end
    endtask

    task automatic test_sym_err();
        clear_log();
        send_sym(4'd11);
        @(negedge clk);
        tests++; if (sym_err !== 1'b1) begin fails++; $display("FAIL sym_err_set: got %0b exp 1", sym_err); end
        @(posedge clk); #1;
        send_sym(4'd0);
        do_flush();
        idle(6);
        tests++; if (got_word.size() != 1) begin fails++; $display("FAIL err_count: got %0d exp 1", got_word.size()); end
        else begin
            tests++; if (got_word[0] !== 32'h8000_0000) begin fails++; $display("FAIL err_word: got %h exp 80000000", got_word[0]); end
            tests++; if (got_bits[0] !== 6'd1) begin fails++; $display("FAIL err_bits: got %0d exp 1", got_bits[0]); end
        end
        tests++; if (sym_err !== 1'b1) begin fails++; $display("FAIL sym_err_sticky: got %0b exp 1", sym_err); end
    endtask

    task automatic test_backpressure();
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) send_sym(4'd0);
        idle(3);
        @(negedge clk);
        tests++; if (sym_ready !== 1'b0) begin fails++; $display("FAIL bp_sym_ready: got %0b exp 0", sym_ready); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid: got %0b exp 1", out_valid); end
        tests++; if (out_word !== 32'hFFFF_FFFF) begin fails++; $display("FAIL bp_hold_word: got %h exp ffffffff", out_word); end
        @(negedge clk);
        tests++; if (out_word !== 32'hFFFF_FFFF || out_bits !== 6'd32) begin fails++; $display("FAIL bp_hold_stable: got %h/%0d exp ffffffff/32", out_word, out_bits); end
        tests++; if (got_word.size() != 0) begin fails++; $display("FAIL bp_no_xfer: got %0d exp 0", got_word.size()); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(6);
        tests++; if (got_word.size() != 2) begin fails++; $display("FAIL bp_count: got %0d exp 2", got_word.size()); end
        else begin
            tests++; if (got_word[0] !== 32'hFFFF_FFFF || got_word[1] !== 32'hFFFF_FFFF) begin
                fails++; $display("FAIL bp_words: got %h %h exp ffffffff ffffffff", got_word[0], got_word[1]);
            end
        end
        @(negedge clk);
        tests++; if (sym_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_recover: ready/valid got %0b/%0b exp 1/0", sym_ready, out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_empty();
        clear_log();
        flush = 1'b1;
        @(negedge clk);
        tests++; if (sym_ready !== 1'b1) begin fails++; $display("FAIL fe_ready: got %0b exp 1", sym_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        tests++; if (flush_done !== 1'b1) begin fails++; $display("FAIL fe_done_pulse: got %0b exp 1", flush_done); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fe_no_valid: got %0b exp 0", out_valid); end
        @(negedge clk);
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL fe_done_one_cycle: got %0b exp 0", flush_done); end
        @(posedge clk); #1;
        // Flush together with symbol 7: the symbol is included
        sym_in = 4'd7; sym_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        sym_valid = 1'b0; flush = 1'b0;
        idle(6);
        tests++; if (got_word.size() != 1) begin fails++; $display("FAIL fs7_count: got %0d exp 1", got_word.size()); end
        else begin
            tests++; if (got_word[0] !== 32'h6800_0000) begin fails++; $display("FAIL fs7_word: got %h exp 68000000", got_word[0]); end
            tests++; if (got_bits[0] !== 6'd5) begin fails++; $display("FAIL fs7_bits: got %0d exp 5", got_bits[0]); end
        end
        tests++; if (done_cnt != 2) begin fails++; $display("FAIL fs7_done: got %0d exp 2", done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_sym(4'd9); send_sym(4'd2); send_sym(4'd1); send_sym(4'd6); send_sym(4'd5);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || out_bits !== 6'd0) begin fails++; $display("FAIL rm_outputs: valid/bits got %0b/%0d exp 0/0", out_valid, out_bits); end
        tests++; if (sym_err !== 1'b0) begin fails++; $display("FAIL rm_sym_err: got %0b exp 0", sym_err); end
        @(posedge clk); #1;
        do_flush();
        idle(6);
        tests++; if (got_word.size() != 0) begin fails++; $display("FAIL rm_no_word: got %0d exp 0", got_word.size()); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL rm_done: got %0d exp 1", done_cnt); end
    endtask

    initial begin
        tests = 0; fails = 0; done_cnt = 0;
        rst = 1'b0; sym_in = 4'd0; sym_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        test_reset();
        test_full_word();
        test_flush_mixed();
        test_sym_err();
        test_backpressure();
        test_flush_empty();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
